// File: rtl/memctl_pkg.sv
// Shared codes and sizing helpers for the multi-outstanding memory controller.
`ifndef CLOG2
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package memctl_pkg;
  localparam logic [1:0] RW_IDLE  = 2'd0;
  localparam logic [1:0] RW_READ  = 2'd1;
  localparam logic [1:0] RW_WRITE = 2'd2;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int send_byte(int dwb, int awb);
    return dwb + awb + dwb / 8 + 1;
  endfunction
endpackage

// File: rtl/memctl_order_fifo.sv
// Port-id order FIFO: remembers which port owns each in-flight read so responses return in issue order.
module memctl_order_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = `CLOG2(DEPTH);
  localparam int CW = `CLOG2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_wptr, r_rptr;
  logic [CW-1:0]           r_cnt;
  logic                    w_push_ok, w_pop_ok;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_data    = r_mem[r_rptr];
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop frees the head slot, so a full FIFO may still take a push that cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop_ok)
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/memory_controller_mo.sv
// Multi-outstanding port arbiter onto the memory packet link; reads return in issue order.
// MEMCTL_RR_ARB_EN selects round-robin arbitration, otherwise fixed priority (lowest port wins).
module memory_controller_mo
  import memctl_pkg::*;
#(
  parameter int  PORT_COUNT      = 4,
  parameter int  DATA_WIDTH_BYTE = 4,
  parameter int  ADDR_WIDTH_BYTE = 4,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int DW = 8 * DATA_WIDTH_BYTE,
  localparam int AW = 8 * ADDR_WIDTH_BYTE,
  localparam int SB = send_byte(DATA_WIDTH_BYTE, ADDR_WIDTH_BYTE),
  localparam int SW = 8 * SB
) (
  input  logic                                CLK,
  input  logic                                RST,
  output logic                                send_flag,
  output logic [SW-1:0]                       send_data,
  output logic [4:0]                          send_length,
  input  logic                                sendable,
  output logic                                recv_flag,
  input  logic [SW-1:0]                       recv_data,
  input  logic                                receivable,
  input  logic [2*PORT_COUNT-1:0]             rw_flag_,
  input  logic [AW*PORT_COUNT-1:0]            addr_,
  input  logic [DW*PORT_COUNT-1:0]            write_data_,
  input  logic [DATA_WIDTH_BYTE*PORT_COUNT-1:0] write_mask_,
  output logic [DW*PORT_COUNT-1:0]            read_data_,
  output logic [PORT_COUNT-1:0]               busy,
  output logic [PORT_COUNT-1:0]               done,
  output logic                                proto_err
);
  localparam int PW  = `CLOG2(PORT_COUNT);
  localparam int WPK = 1 + DATA_WIDTH_BYTE + AW + DW;

  logic [PORT_COUNT-1:0]                      r_busy, r_sent, r_is_wr;
  logic [PORT_COUNT-1:0][AW-1:0]              r_addr;
  logic [PORT_COUNT-1:0][DW-1:0]              r_wdata, r_rdata;
  logic [PORT_COUNT-1:0][DATA_WIDTH_BYTE-1:0] r_mask;

  logic [PORT_COUNT-1:0] w_elig;
  logic [PW-1:0]         w_gnt, w_head;
  logic                  w_gnt_vld, w_push, w_pop, w_full, w_empty;
  logic                  w_unused_recv;

  assign w_unused_recv = ^recv_data[SW-1:DW];

  memctl_order_fifo #(.W(PW), .DEPTH(MAX_OUTSTANDING)) u_order (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_push (w_push),
    .i_data (w_gnt),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign w_pop      = receivable && !w_empty && !RST;
  assign recv_flag  = receivable && !RST;
  assign proto_err  = receivable && w_empty && !RST;
  assign w_push     = w_gnt_vld && !r_is_wr[w_gnt];
  assign busy       = r_busy;
  assign read_data_ = r_rdata;

`ifdef MEMCTL_RR_ARB_EN
  logic [PW-1:0] r_rr_ptr;

  function automatic int rr_idx(logic [PW-1:0] ptr, int i);
    int s;
    s = int'(ptr) + i;
    return (s >= PORT_COUNT) ? s - PORT_COUNT : s;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST)            r_rr_ptr <= '0;
    else if (w_gnt_vld) r_rr_ptr <= (w_gnt == PW'(PORT_COUNT - 1)) ? '0 : w_gnt + 1'b1;
  end
`endif

  always_comb begin
    w_elig = '0;
    for (int p = 0; p < PORT_COUNT; p++)
      w_elig[p] = r_busy[p] && !r_sent[p] && (r_is_wr[p] || !w_full || w_pop);
    w_gnt = '0;
    // Scan from farthest to nearest so the last hit is the winner.
`ifdef MEMCTL_RR_ARB_EN
    for (int i = PORT_COUNT - 1; i >= 0; i--)
      if (w_elig[rr_idx(r_rr_ptr, i)]) w_gnt = PW'(rr_idx(r_rr_ptr, i));
`else
    for (int p = PORT_COUNT - 1; p >= 0; p--)
      if (w_elig[p]) w_gnt = PW'(p);
`endif
    w_gnt_vld = sendable && (|w_elig) && !RST;
  end

  always_comb begin
    send_flag   = w_gnt_vld;
    send_data   = '0;
    send_length = '0;
    done        = '0;
    if (w_gnt_vld) begin
      if (r_is_wr[w_gnt]) begin
        send_data[WPK-1:0] = {OP_WRITE, r_mask[w_gnt], r_addr[w_gnt], r_wdata[w_gnt]};
        send_length        = 5'(SB);
        done[w_gnt]        = 1'b1;
      end else begin
        send_data[AW:0] = {OP_READ, r_addr[w_gnt]};
        send_length     = 5'(ADDR_WIDTH_BYTE + 1);
      end
    end
    if (w_pop) done[w_head] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_busy  <= '0;
      r_sent  <= '0;
      r_is_wr <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
    end else begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (!r_busy[p] && (rw_flag_[2*p +: 2] == RW_READ || rw_flag_[2*p +: 2] == RW_WRITE)) begin
          r_busy[p]  <= 1'b1;
          r_sent[p]  <= 1'b0;
          r_is_wr[p] <= (rw_flag_[2*p +: 2] == RW_WRITE);
          r_addr[p]  <= addr_[AW*p +: AW];
          r_wdata[p] <= write_data_[DW*p +: DW];
          r_mask[p]  <= write_mask_[DATA_WIDTH_BYTE*p +: DATA_WIDTH_BYTE];
        end
      end
      // Writes retire on issue; reads stay busy until their response pops.
      if (w_gnt_vld) begin
        if (r_is_wr[w_gnt]) r_busy[w_gnt] <= 1'b0;
        else                r_sent[w_gnt] <= 1'b1;
      end
      if (w_pop) begin
        r_busy[w_head]  <= 1'b0;
        r_sent[w_head]  <= 1'b0;
        r_rdata[w_head] <= recv_data[DW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_memory_controller_mo.sv
// Scoreboard bench: expected sends/completions queued by stimulus, checked by a negedge monitor.
module tb_memory_controller_mo;
  import memctl_pkg::*;

  logic        CLK = 0, RST;
  logic        send_flag, sendable, recv_flag, receivable, proto_err;
  logic [71:0] send_data, recv_data;
  logic [4:0]  send_length;
  logic [7:0]  rw_flag_;
  logic [127:0] addr_, write_data_, read_data_;
  logic [15:0] write_mask_;
  logic [3:0]  busy, done;

  logic        b_send_flag, b_sendable, b_recv_flag, b_receivable, b_proto_err;
  logic [71:0] b_send_data;
  logic [4:0]  b_send_length;
  logic [7:0]  b_rw_flag;
  logic [127:0] b_read_data;
  logic [3:0]  b_busy, b_done;

  always #5 CLK = ~CLK;

  memory_controller_mo dut (
    .CLK(CLK), .RST(RST), .send_flag(send_flag), .send_data(send_data), .send_length(send_length),
    .sendable(sendable), .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable),
    .rw_flag_(rw_flag_), .addr_(addr_), .write_data_(write_data_), .write_mask_(write_mask_),
    .read_data_(read_data_), .busy(busy), .done(done), .proto_err(proto_err));

  memory_controller_mo #(.MAX_OUTSTANDING(2)) dut2 (
    .CLK(CLK), .RST(RST), .send_flag(b_send_flag), .send_data(b_send_data), .send_length(b_send_length),
    .sendable(b_sendable), .recv_flag(b_recv_flag), .recv_data(recv_data), .receivable(b_receivable),
    .rw_flag_(b_rw_flag), .addr_(addr_), .write_data_(write_data_), .write_mask_(write_mask_),
    .read_data_(b_read_data), .busy(b_busy), .done(b_done), .proto_err(b_proto_err));

  typedef struct { logic [71:0] data; logic [4:0] len; } send_t;
  typedef struct { int port; logic is_rd; logic [31:0] data; } done_t;
  send_t sq[$];
  done_t dq[$];

  int n_tests = 0, n_fail = 0, n_perr = 0;
  bit mon_en = 1;
  bit        pend_v[4];
  logic [31:0] pend_d[4];

  task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [71:0] rd_pkt(logic [31:0] a);
    logic [71:0] v;
    v = '0;
    v[32:0] = {1'b0, a};
    return v;
  endfunction

  function automatic logic [71:0] wr_pkt(logic [3:0] m, logic [31:0] a, logic [31:0] d);
    logic [71:0] v;
    v = '0;
    v[68:0] = {1'b1, m, a, d};
    return v;
  endfunction

  function automatic logic [31:0] adr(int p);
    return 32'h1000_0000 + 32'(p * 16);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_port(int p, logic [1:0] f, logic [31:0] d, logic [3:0] m);
    rw_flag_[2*p +: 2]     = f;
    addr_[32*p +: 32]      = adr(p);
    write_data_[32*p +: 32] = d;
    write_mask_[4*p +: 4]  = m;
  endtask

  task automatic exp_read(int p, logic [31:0] d, bit completes);
    send_t s;
    done_t e;
    s.data = rd_pkt(adr(p)); s.len = 5'd5;
    sq.push_back(s);
    if (completes) begin
      e.port = p; e.is_rd = 1'b1; e.data = d;
      dq.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && mon_en) begin
      for (int p = 0; p < 4; p++)
        if (pend_v[p]) begin
          chk("read_data", read_data_[32*p +: 32], pend_d[p]);
          pend_v[p] = 0;
        end
      if (send_flag) begin
        if (sq.size() == 0) fail("send_unexpected");
        else begin
          send_t s;
          s = sq.pop_front();
          chk("send_data", send_data, s.data);
          chk("send_length", send_length, s.len);
        end
      end
      for (int p = 0; p < 4; p++)
        if (done[p]) begin
          if (dq.size() == 0) fail("done_unexpected");
          else begin
            done_t e;
            e = dq.pop_front();
            chk("done_port", p, e.port);
            if (e.is_rd) begin pend_v[p] = 1; pend_d[p] = e.data; end
          end
        end
      if (proto_err) n_perr++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    int exp_g[5];
    send_t s;
    done_t e;
    RST = 1; sendable = 1; receivable = 1; recv_data = '0;
    rw_flag_ = '0; addr_ = '0; write_data_ = '0; write_mask_ = '0;
    b_rw_flag = '0; b_sendable = 0; b_receivable = 0;
    repeat (3) tick();
    chk("rst_busy", busy, 4'b0);
    chk("rst_send_flag", send_flag, 0);
    chk("rst_recv_flag", recv_flag, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_read_data", read_data_, '0);
    receivable = 0; RST = 0;
    tick();

    // 1: write on port 2
    set_port(2, RW_WRITE, 32'hCAFE_0002, 4'b1010);
    s.data = wr_pkt(4'b1010, adr(2), 32'hCAFE_0002); s.len = 5'd9; sq.push_back(s);
    e.port = 2; e.is_rd = 0; e.data = '0; dq.push_back(e);
    tick();
    rw_flag_ = '0; #1;
    chk("wr_send_flag", send_flag, 1);
    chk("wr_done", done, 4'b0100);
    chk("wr_len", send_length, 5'd9);
    tick();
    chk("wr_busy_clear", busy, 4'b0);
    tick();

    // 2: staggered reads on 0,1,3, delayed responses
    exp_read(0, 32'hA, 1); exp_read(1, 32'hB, 1); exp_read(3, 32'hC, 1);
    set_port(0, RW_READ, '0, '0); tick();
    rw_flag_ = '0; set_port(1, RW_READ, '0, '0); #1;
    chk("rd_send0", send_flag, 1);
    tick();
    rw_flag_ = '0; set_port(3, RW_READ, '0, '0); #1;
    chk("rd_send1", send_flag, 1);
    tick();
    rw_flag_ = '0; #1;
    chk("rd_send3", send_flag, 1);
    repeat (10) tick();
    chk("rd_busy_wait", busy, 4'b1011);
    recv_data = {40'hA5A5A5A5A5, 32'hA}; receivable = 1; #1;
    chk("rd_done0", done, 4'b0001);
    chk("rd_recv_flag", recv_flag, 1);
    tick(); recv_data[31:0] = 32'hB; #1;
    chk("rd_done1", done, 4'b0010);
    tick(); recv_data[31:0] = 32'hC; #1;
    chk("rd_done3", done, 4'b1000);
    tick(); receivable = 0;
    tick();
    chk("rd_busy_clear", busy, 4'b0);
    chk("rd_data_all", read_data_, {32'hC, 32'h0, 32'hB, 32'hA});

    // 4: all ports re-requesting writes
`ifdef MEMCTL_RR_ARB_EN
    exp_g = '{0, 1, 2, 3, 0};
`else
    exp_g = '{0, 1, 0, 1, 0};
`endif
    mon_en = 0;
    for (int p = 0; p < 4; p++) set_port(p, RW_WRITE, 32'hD000_0000 + 32'(p), 4'hF);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("arb_grant", done, 4'(1 << exp_g[i]));
      tick();
    end
    rw_flag_ = '0;
    k = 0;
    while (busy != 0 && k < 20) begin tick(); k++; end
    if (k >= 20) fail("arb_drain_timeout");
    tick();
    mon_en = 1;

    // 5: response with nothing in flight
    base = n_perr;
    receivable = 1; #1;
    chk("perr_flag", proto_err, 1);
    chk("perr_recv_flag", recv_flag, 1);
    chk("perr_no_done", done, 4'b0);
    tick(); receivable = 0;
    chk("perr_count", n_perr, base + 1);

    // 3: MAX_OUTSTANDING=2 stall then issue with the pop
    b_sendable = 1; b_rw_flag = 8'b01010101;
    tick();
    b_rw_flag = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mo2_send", b_send_flag, (i < 2) ? 1 : 0);
      tick();
    end
    chk("mo2_busy_stall", b_busy, 4'b1111);
    b_receivable = 1; #1;
    chk("mo2_send_on_pop", b_send_flag, 1);
    chk("mo2_recv_flag", b_recv_flag, 1);
    chk("mo2_done0", b_done, 4'b0001);
    k = 0;
    while (b_busy != 0 && k < 30) begin tick(); k++; end
    if (k >= 30) fail("mo2_drain_timeout");
    b_receivable = 0;
    tick();

    // 6: reset with two reads in flight
    exp_read(0, '0, 0); exp_read(2, '0, 0);
    set_port(0, RW_READ, '0, '0); tick();
    rw_flag_ = '0; set_port(2, RW_READ, '0, '0); tick();
    rw_flag_ = '0; tick(); tick();
    chk("rst6_inflight", busy, 4'b0101);
    RST = 1; tick(); #1;
    chk("rst6_busy", busy, 4'b0);
    RST = 0; tick();
    recv_data = {40'h0, 32'hDEAD}; receivable = 1; #1;
    chk("rst6_perr", proto_err, 1);
    chk("rst6_no_done", done, 4'b0);
    tick(); receivable = 0;
    exp_read(1, 32'h77, 1);
    set_port(1, RW_READ, '0, '0); tick();
    rw_flag_ = '0; tick();
    chk("rst6_rd_busy", busy, 4'b0010);
    recv_data = {40'h0, 32'h77}; receivable = 1; #1;
    chk("rst6_done1", done, 4'b0010);
    tick(); receivable = 0;
    tick(); tick();
    chk("rst6_busy_end", busy, 4'b0);
    chk("rst6_rdata1", read_data_[63:32], 32'h77);

    chk("sq_drained", sq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
